serial_add_ctrl: RTL



---
 rtl/serial_add_ctrl_pkg.sv | 14 +
 rtl/serial_add_ctrl_fa_cell.sv | 15 +
 rtl/serial_add_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder sequencer.
//   ST_IDLE / ST_RUN / ST_DONE : 2-bit FSM state encodings
//   cnt_width(w)               : bit-counter width, ceil(log2(w+1))
package serial_add_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// Purely combinational 1-bit full adder.
//   a, b, ci : addend bits and carry-in
//   s, co    : sum bit and carry-out
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: latches a, b, cin on an accepted start and
// steps a single full-adder cell LSB-first for WIDTH clocks.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : request; accepted in IDLE or DONE
//   a, b, cin  : operands, sampled only on the accepting edge
//   busy       : high in RUN
//   done       : one-cycle pulse, sum/cout valid
//   sum, cout  : result, held until the next RUN->DONE transition
//
// state   | meaning
// IDLE    | waiting for start
// RUN     | one operand bit per clock, LSB first
// DONE    | result valid for one cycle; start here restarts with no gap
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = cnt_width(WIDTH);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_next;
  logic             c;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             fa_s;
  logic             fa_co;
  logic             last_bit;

  fa_cell u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (c),
    .s  (fa_s),
    .co (fa_co)
  );

  // Result register shifts right with the new bit entering at the MSB, so
  // after WIDTH steps the first (LSB) bit has reached position 0.
  generate
    if (WIDTH == 1) begin : g_r1
      assign r_next = fa_s;
    end else begin : g_rn
      assign r_next = {fa_s, r_sh[WIDTH-1:1]};
    end
  endgenerate

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      c      <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            c     <= cin;
            cnt   <= '0;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          r_sh <= r_next;
          c    <= fa_co;
          cnt  <= cnt + CNT_W'(1);
          if (last_bit) begin
            sum_q  <= r_next;
            cout_q <= fa_co;
            state  <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
